// File: rtl/button_pulser.sv
// button_pulser: synchronises, debounces and edge-strobes bouncy push-button and switch inputs
module button_pulser #(
  parameter int WIDTH = 5,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter logic [WIDTH-1:0] EDGE_MASK = 5'b10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] level,
  output logic             ready
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [2:0] {INIT, IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;
  state_t state [WIDTH];
  state_t state_n [WIDTH];
  logic [CW-1:0] cnt [WIDTH];
  logic [CW-1:0] cnt_n [WIDTH];
  logic [WIDTH-1:0] s1, s2, tracked, tracked_n, level_n, pulse_n, not_init;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      tracked <= '0;
      level <= '0;
      pulse <= '0;
      ready <= 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        state[k] <= INIT;
        cnt[k] <= '0;
      end
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      tracked <= tracked_n;
      level <= level_n;
      pulse <= pulse_n;
      ready <= &not_init;
      for (int k = 0; k < WIDTH; k++) begin
        state[k] <= state_n[k];
        cnt[k] <= cnt_n[k];
      end
    end
  end
  // INIT learns the level present at reset and settles silently, so held inputs never strobe
  always_comb begin
    tracked_n = tracked;
    level_n = level;
    pulse_n = '0;
    not_init = '0;
    for (int k = 0; k < WIDTH; k++) begin
      state_n[k] = state[k];
      cnt_n[k] = cnt[k];
      case (state[k])
        INIT:
          if (s2[k] != tracked[k]) begin
            tracked_n[k] = s2[k];
            cnt_n[k] = CW'(1);
          end else if (cnt[k] == LAST) begin
            state_n[k] = tracked[k] ? HELD : IDLE;
            level_n[k] = tracked[k];
            cnt_n[k] = '0;
          end else cnt_n[k] = cnt[k] + 1'b1;
        IDLE:
          if (s2[k]) begin
            state_n[k] = CONFIRM_PRESS;
            cnt_n[k] = CW'(1);
          end
        CONFIRM_PRESS:
          if (!s2[k]) begin
            state_n[k] = IDLE;
            cnt_n[k] = '0;
          end else if (cnt[k] == LAST) begin
            state_n[k] = HELD;
            level_n[k] = 1'b1;
            pulse_n[k] = 1'b1;
            cnt_n[k] = '0;
          end else cnt_n[k] = cnt[k] + 1'b1;
        HELD:
          if (!s2[k]) begin
            state_n[k] = CONFIRM_RELEASE;
            cnt_n[k] = CW'(1);
          end
        CONFIRM_RELEASE:
          if (s2[k]) begin
            state_n[k] = HELD;
            cnt_n[k] = '0;
          end else if (cnt[k] == LAST) begin
            state_n[k] = IDLE;
            level_n[k] = 1'b0;
            pulse_n[k] = EDGE_MASK[k];
            cnt_n[k] = '0;
          end else cnt_n[k] = cnt[k] + 1'b1;
        default: begin
          state_n[k] = INIT;
          cnt_n[k] = '0;
        end
      endcase
      not_init[k] = state_n[k] != INIT;
    end
  end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: directed scoreboard bench for button_pulser with a short debounce window
module tb_button_pulser;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] pulse, level;
  logic ready;
  int compared = 0;
  int mismatched = 0;
  typedef struct {logic [4:0] p; logic [4:0] l; logic r;} exp_t;
  exp_t q[$];

  button_pulser #(.WIDTH(5), .DEBOUNCE_CYCLES(N), .EDGE_MASK(5'b10000)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .pulse(pulse), .level(level), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: got %b want %b", tag, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] p, input logic [4:0] l, input logic r, input int n);
    exp_t e;
    e.p = p;
    e.l = l;
    e.r = r;
    repeat (n) q.push_back(e);
  endtask

  task automatic step(input string tag, input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL %s: scoreboard empty, got pulse %b level %b", tag, pulse, level);
      end else begin
        e = q.pop_front();
        chk({tag, ".pulse"}, pulse, e.p);
        chk({tag, ".level"}, level, e.l);
        chk({tag, ".ready"}, {4'b0, ready}, {4'b0, e.r});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst.pulse", pulse, 5'b0);
    chk("rst.level", level, 5'b0);
    chk("rst.ready", {4'b0, ready}, 5'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push(5'h00, 5'h00, 1'b0, 3);
    push(5'h00, 5'h00, 1'b1, 3);
    step("idle", 6);
    btn_raw[0] = 1'b1;
    push(5'h00, 5'h00, 1'b1, 5);
    push(5'h01, 5'h01, 1'b1, 1);
    push(5'h00, 5'h01, 1'b1, 3);
    step("press0", 9);
    btn_raw[0] = 1'b0;
    push(5'h00, 5'h01, 1'b1, 5);
    push(5'h00, 5'h00, 1'b1, 4);
    step("rel0", 9);
    btn_raw[4] = 1'b1;
    push(5'h00, 5'h00, 1'b1, 9);
    push(5'h10, 5'h10, 1'b1, 1);
    push(5'h00, 5'h10, 1'b1, 4);
    step("bounce4", 3);
    btn_raw[4] = 1'b0;
    step("bounce4", 1);
    btn_raw[4] = 1'b1;
    step("bounce4", 10);
    btn_raw[4] = 1'b0;
    push(5'h00, 5'h10, 1'b1, 5);
    push(5'h10, 5'h00, 1'b1, 1);
    push(5'h00, 5'h00, 1'b1, 3);
    step("rel4", 9);
    btn_raw[1] = 1'b1;
    push(5'h00, 5'h00, 1'b1, 10);
    step("glitch1", 3);
    btn_raw[1] = 1'b0;
    step("glitch1", 7);
    btn_raw[2] = 1'b1;
    push(5'h00, 5'h00, 1'b1, 5);
    push(5'h04, 5'h04, 1'b1, 1);
    push(5'h00, 5'h04, 1'b1, 2);
    step("press2", 8);
    #3 reset = 1'b1;
    #1;
    chk("midrst.pulse", pulse, 5'b0);
    chk("midrst.level", level, 5'b0);
    chk("midrst.ready", {4'b0, ready}, 5'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    push(5'h00, 5'h00, 1'b0, 5);
    push(5'h00, 5'h04, 1'b1, 3);
    step("held_rst2", 8);
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    push(5'h00, 5'h04, 1'b1, 5);
    push(5'h09, 5'h0d, 1'b1, 1);
    push(5'h00, 5'h0d, 1'b1, 2);
    step("dual", 8);
    compared++;
    assert (q.size() == 0) else begin
      mismatched++;
      $error("FAIL drain: got %0d leftover want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/button_pulser.md
# button_pulser

Front-end conditioning stage for the calculator's push-buttons and the sign switch. Synchronises five raw inputs to `clk` (500 Hz), debounces each with a per-channel state machine, and emits one-cycle `pulse` strobes plus clean `level` outputs. Sits directly upstream of the sign-toggle and operand-entry logic, which consume `pulse[4:0]`. Channel 4 is the negative-sign switch and strobes on both edges; channels 0-3 strobe on press only.

## Interface
- `WIDTH`, 5, number of input channels.
- `DEBOUNCE_CYCLES`, 10, consecutive stable samples (N) required to accept a change; N ≥ 2 (20 ms at 500 Hz).
- `EDGE_MASK`, 5'b10000, per channel: 1 = pulse on press and release, 0 = pulse on press only.
- `clk`  in  1  system clock (500 Hz); all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  WIDTH  raw, asynchronous, bouncy button/switch levels (1 = pressed/on).
- `pulse`  out  WIDTH  registered one-cycle strobe per accepted edge.
- `level`  out  WIDTH  registered debounced level.
- `ready`  out  1  high once every channel has left INIT.

## Operation
- Per channel: 2-FF synchroniser (`s1`→`s2`), reset to 0. FSM samples `s2` only.
- Counter per channel, width $clog2(DEBOUNCE_CYCLES); never exceeds N-1.
- States: INIT, IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
- INIT (reset state, cnt=0, tracked=0): `s2`==tracked → if cnt==N-1 go IDLE (tracked 0) or HELD (tracked 1, `level`←1), else cnt++; `s2`≠tracked → tracked←`s2`, cnt←1. No pulse on leaving INIT, so an input held through reset never strobes.
- IDLE: `s2`=1 → CONFIRM_PRESS, cnt←1.
- CONFIRM_PRESS: `s2`=0 → IDLE, cnt←0. `s2`=1 and cnt==N-1 → HELD, `level`←1, `pulse`←1. Else cnt++.
- HELD: `s2`=0 → CONFIRM_RELEASE, cnt←1.
- CONFIRM_RELEASE: `s2`=1 → HELD, cnt←0. `s2`=0 and cnt==N-1 → IDLE, `level`←0, `pulse`←EDGE_MASK[i]. Else cnt++.
- `pulse` deasserts the following cycle unconditionally; never high two consecutive cycles on one channel.
- Channels independent; simultaneous pulses on several channels allowed and not arbitrated.
- `ready` = AND over channels of (state ≠ INIT), registered.

## Timing
- Reset (async assert): `pulse`=0, `level`=0, `ready`=0, sync FFs 0, all FSMs INIT, cnt=0. Takes effect immediately; mid-debounce progress discarded.
- Press latency: raw rising before edge 0 and held stable → `s2`=1 sampled first at edge 2 → `pulse` high for exactly the cycle after edge N+1 (the (N+2)th edge). Release latency identical.
- Glitch rejection: `s2` high for fewer than N consecutive samples → no pulse, `level` unchanged.
- Bounce during confirm restarts the count from the next qualifying sample; no partial credit.
- After reset with raw stable low: `ready` high after edge N-1 (Nth edge). Raw stable high: `ready` and `level` high after edge N+1, `pulse` stays 0.
- Reset asserted in HELD with input still held: after reset channel reaches HELD via INIT silently; next strobe only on release (if masked) or a new press.

## Test plan
- N=4, all raw low through reset release → `ready`=1 after 4th edge; `pulse`=0, `level`=0 throughout.
- N=4, after ready, raise `btn_raw[0]` before edge 0 and hold → `pulse[0]`=1 for exactly the cycle after 6th edge, `level[0]`=1 from then; release → `level[0]`=0 after 6th edge, `pulse[0]` stays 0.
- N=4, `btn_raw[4]` high 3 cycles, low 1, high 10 → one `pulse[4]` only, 6 edges after the final rise; then release → second `pulse[4]` 6 edges after fall (EDGE_MASK bit).
- N=4, `btn_raw[1]` high for exactly 3 cycles → no pulse, `level[1]`=0.
- N=4, `btn_raw[2]` held high across a reset pulse asserted mid-cycle → outputs 0 immediately; after release of reset `level[2]`=1 after 6th edge with no `pulse[2]`.
- N=4, `btn_raw[0]` and `btn_raw[3]` rise same cycle → `pulse[0]` and `pulse[3]` asserted in the same cycle, each exactly one cycle.
